// File: rtl/hub75_pkg.sv
// HUB75 BCM scheduler package: FSM state encoding, default geometry and
// timing values, and width helpers shared by the scheduler and its on-timer.
package hub75_pkg;

  localparam int unsigned NUM_ROWS_DEFAULT  = 32;
  localparam int unsigned PLANES_DEFAULT    = 8;
  localparam int unsigned BASE_ON_DEFAULT   = 64;
  localparam int unsigned LATCH_CYC_DEFAULT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT_ON,
    S_BLANK,
    S_LATCH
  } state_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // On-timer width: must hold the longest plane, base_on << (planes-1).
  function automatic int unsigned timer_width(input int unsigned base_on,
                                              input int unsigned planes);
    return idx_width((base_on << (planes - 1)) + 1);
  endfunction

endpackage

// File: rtl/hub75_on_timer.sv
// HUB75 on-timer: loadable down-counter that holds NOE low while nonzero.
// Clear has priority over load; the count stops at zero and never wraps.
module hub75_on_timer
  import hub75_pkg::*;
#(
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_noe_low
);

  logic [TW-1:0] r_count;

  // Count down once per cycle after a load; clear or reset empties it.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_noe_low = (r_count != '0);

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 binary-code-modulation scheduler. Requests a column shift for each
// (row, plane), latches it, and displays it for BASE_ON << plane cycles while
// the next plane is being shifted in.
// Optional feature macro: HUB75_BRIGHT_EN adds the i_brightness port and scales
// the on-time by brightness/256.
module hub75_bcm_scheduler
  import hub75_pkg::*;
#(
  parameter  int unsigned NUM_ROWS  = NUM_ROWS_DEFAULT,
  parameter  int unsigned PLANES    = PLANES_DEFAULT,
  parameter  int unsigned BASE_ON   = BASE_ON_DEFAULT,
  parameter  int unsigned LATCH_CYC = LATCH_CYC_DEFAULT,
  localparam int unsigned RW        = idx_width(NUM_ROWS),
  localparam int unsigned PW        = idx_width(PLANES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enable,
  output logic          o_shift_start,
  output logic [RW-1:0] o_shift_row,
  output logic [PW-1:0] o_shift_plane,
  input  logic          i_shift_done,
  output logic          o_latch,
  output logic          o_noe,
  output logic [RW-1:0] o_row,
  output logic          o_frame_sync
`ifdef HUB75_BRIGHT_EN
  ,
  input  logic [7:0]    i_brightness
`endif
);

  localparam int unsigned TW = timer_width(BASE_ON, PLANES);
  localparam int unsigned LW = idx_width(LATCH_CYC);

  localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_ROWS - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(LATCH_CYC - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_shift_start;
  logic [RW-1:0] r_shift_row;
  logic [PW-1:0] r_shift_plane;
  logic [RW-1:0] r_row;
  logic [LW-1:0] r_lat_cnt;
  logic          r_stop;

  logic          w_done_ok;
  logic          w_start_first;
  logic          w_latch_exit;
  logic          w_plane_wrap;
  logic          w_row_wrap;
  logic          w_noe_low;
  logic [TW-1:0] w_base;
  logic [TW-1:0] w_load_val;

  // A done arriving with the start pulse belongs to no accepted transfer.
  assign w_done_ok     = i_shift_done && !r_shift_start;
  assign w_start_first = (r_state == S_IDLE) && i_enable;
  assign w_latch_exit  = (r_state == S_LATCH) && i_enable && (r_lat_cnt == LAT_LAST);
  assign w_plane_wrap  = (r_shift_plane == PLANE_LAST);
  assign w_row_wrap    = (r_shift_row == ROW_LAST);

`ifdef HUB75_BRIGHT_EN
  logic [TW+7:0] w_scaled;
  // BASE_ON*brightness < BASE_ON*256, so the top TW bits hold the quotient.
  assign w_scaled = (TW+8)'(BASE_ON) * (TW+8)'(i_brightness);
  assign w_base   = w_scaled[TW+7:8];
`else
  assign w_base   = TW'(BASE_ON);
`endif

  // The plane just latched sets its own display time.
  assign w_load_val = w_base << r_shift_plane;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a dropped enable returns to IDLE except mid-transfer.
  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch
    // is inferred when a branch below does not mention the signal.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_done_ok) w_next_state = (r_stop || !i_enable) ? S_IDLE : S_WAIT_ON;
      end
      S_WAIT_ON: begin
        if (!i_enable)      w_next_state = S_IDLE;
        else if (!w_noe_low) w_next_state = S_BLANK;
      end
      S_BLANK: begin
        w_next_state = i_enable ? S_LATCH : S_IDLE;
      end
      S_LATCH: begin
        if (!i_enable)         w_next_state = S_IDLE;
        else if (w_latch_exit) w_next_state = S_SHIFT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Shift request, row/plane sequencing, panel row and latch-length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_start <= 1'b0;
      r_shift_row   <= '0;
      r_shift_plane <= '0;
      r_row         <= '0;
      r_lat_cnt     <= '0;
      r_stop        <= 1'b0;
    end else begin
      r_shift_start <= w_start_first || w_latch_exit;

      if (w_start_first) begin
        r_shift_row   <= '0;
        r_shift_plane <= '0;
      end else if (w_latch_exit) begin
        if (w_plane_wrap) begin
          r_shift_plane <= '0;
          r_shift_row   <= w_row_wrap ? '0 : r_shift_row + RW'(1);
        end else begin
          r_shift_plane <= r_shift_plane + PW'(1);
        end
      end

      if ((r_state == S_BLANK) && i_enable) r_row <= r_shift_row;

      r_lat_cnt <= ((r_state == S_LATCH) && (w_next_state == S_LATCH)) ?
                   r_lat_cnt + LW'(1) : '0;

      // Remember a stop request seen at any point of the transfer.
      if (r_state != S_SHIFT) r_stop <= 1'b0;
      else if (!i_enable)     r_stop <= 1'b1;
    end
  end

  hub75_on_timer #(
    .TW (TW)
  ) u_on_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (!i_enable),
    .i_load     (w_latch_exit),
    .i_load_val (w_load_val),
    .o_noe_low  (w_noe_low)
  );

  assign o_shift_start = r_shift_start;
  assign o_shift_row   = r_shift_row;
  assign o_shift_plane = r_shift_plane;
  assign o_row         = r_row;
  assign o_latch       = (r_state == S_LATCH);
  assign o_noe         = !w_noe_low;
  assign o_frame_sync  = w_latch_exit && w_plane_wrap && w_row_wrap;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Directed bench for hub75_bcm_scheduler with NUM_ROWS=4, PLANES=2, BASE_ON=4,
// LATCH_CYC=2 and a shifter model answering done a set delay after start.
module tb_hub75_bcm_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned PL = 2;
  localparam int unsigned BO = 4;
  localparam int unsigned LC = 2;

`ifdef HUB75_BRIGHT_EN
  localparam int B0 = 2;   // (4*128)>>8
`else
  localparam int B0 = 4;
`endif
  localparam int B1 = 2 * B0;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sdone;
  logic       sstart;
  logic [1:0] srow;
  logic [0:0] splane;
  logic       latch;
  logic       noe;
  logic [1:0] row;
  logic       fsync;
`ifdef HUB75_BRIGHT_EN
  logic [7:0] bright;
`endif

  always #5 clk = ~clk;

  hub75_bcm_scheduler #(
    .NUM_ROWS  (NR),
    .PLANES    (PL),
    .BASE_ON   (BO),
    .LATCH_CYC (LC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (en),
    .o_shift_start (sstart),
    .o_shift_row   (srow),
    .o_shift_plane (splane),
    .i_shift_done  (sdone),
    .o_latch       (latch),
    .o_noe         (noe),
    .o_row         (row),
    .o_frame_sync  (fsync)
`ifdef HUB75_BRIGHT_EN
    ,
    .i_brightness  (bright)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observation log filled on falling edges.
  int cyc = 0;
  int noe_runs[$];
  int latch_rows[$];
  int latch_lens[$];
  int latch_cyc[$];
  int start_rows[$];
  int start_planes[$];
  int start_cyc[$];
  int fs_at[$];
  int cur_noe = 0;
  int cur_lat = 0;
  int fs_count = 0;
  int overlap = 0;
  int done_delay = 10;

  task automatic clear_log();
    noe_runs.delete(); latch_rows.delete(); latch_lens.delete(); latch_cyc.delete();
    start_rows.delete(); start_planes.delete(); start_cyc.delete(); fs_at.delete();
    cur_noe = 0; cur_lat = 0; fs_count = 0; overlap = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_latches(input int n);
    int k = 0;
    while (latch_rows.size() < n && k < 500) begin tick(1); k++; end
    if (latch_rows.size() < n) check("latch_wait_timeout", latch_rows.size(), n);
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (start_cyc.size() < n && k < 500) begin tick(1); k++; end
    if (start_cyc.size() < n) check("start_wait_timeout", start_cyc.size(), n);
  endtask

  task automatic go_idle();
    en = 1'b0;
    tick(30);
    clear_log();
  endtask

  // Start-to-start distance: WAIT_ON is left at max(start+2, start+load), then
  // one BLANK cycle, LC latch cycles, and the new start one cycle later.
  function automatic int exp_gap(input int load);
    return ((load > 2) ? load : 2) + 2 + LC;
  endfunction

  // Shifter model: done pulses done_delay cycles after the start pulse.
  initial begin
    int cnt = 0;
    sdone = 1'b0;
    forever begin
      @(negedge clk);
      sdone = 1'b0;
      if (rst) cnt = 0;
      else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) sdone = 1'b1;
      end else if (sstart) cnt = done_delay;
    end
  end

  // Monitor: NOE-low run lengths, latch pulses, frame syncs and start requests.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!noe) cur_noe++;
      else if (cur_noe > 0) begin noe_runs.push_back(cur_noe); cur_noe = 0; end
      if (latch) begin
        if (cur_lat == 0) begin latch_rows.push_back(int'(row)); latch_cyc.push_back(cyc); end
        cur_lat++;
      end else if (cur_lat > 0) begin
        latch_lens.push_back(cur_lat); cur_lat = 0;
      end
      if (fsync) begin fs_count++; fs_at.push_back(latch_rows.size()); end
      if (sstart) begin
        start_rows.push_back(int'(srow)); start_planes.push_back(int'(splane));
        start_cyc.push_back(cyc);
      end
      if (latch && !noe) overlap++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int loads[3];
    int sidx;
    int nl;
    int base;
    int k;
    rst = 1'b1;
    en  = 1'b0;
`ifdef HUB75_BRIGHT_EN
    bright = 8'd128;
`endif
    tick(3);
    check("rst_noe", noe, 1);
    check("rst_latch", latch, 0);
    check("rst_row", row, 0);
    check("rst_start", sstart, 0);
    check("rst_srow", srow, 0);
    check("rst_splane", splane, 0);
    check("rst_fsync", fsync, 0);
    rst = 1'b0;
    tick(2);
    check("idle_noe", noe, 1);
    check("idle_start", sstart, 0);

    // Full frame with the 10-cycle shifter.
    clear_log();
    en = 1'b1;
    tick(1);
    check("first_start", sstart, 1);
    check("first_srow", srow, 0);
    check("first_splane", splane, 0);
    tick(1);
    check("start_one_cycle", sstart, 0);
    wait_latches(9);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("frame_row%0d", i), latch_rows[i], i / 2);
      check($sformatf("latch_len%0d", i), latch_lens[i], LC);
      check($sformatf("noe_run%0d", i), noe_runs[i], (i % 2) ? B1 : B0);
    end
    for (int i = 0; i < 9; i++) begin
      check($sformatf("start_row%0d", i), start_rows[i], (i / 2) % NR);
      check($sformatf("start_plane%0d", i), start_planes[i], i % 2);
    end
    check("frame_sync_count", fs_count, 1);
    check("frame_sync_after_latch", fs_at[0], 8);
    check("start_to_latch", latch_cyc[0] - start_cyc[0], 13);
    check("plane_period", start_cyc[1] - start_cyc[0], 13 + LC);
    check("latch_noe_overlap", overlap, 0);

    // Fast shifter: WAIT_ON holds until the timer expires.
    go_idle();
    done_delay = 1;
    en = 1'b1;
    wait_starts(4);
    loads = '{0, B0, B1};
    for (int i = 1; i < 4; i++)
      check($sformatf("fast_gap%0d", i), start_cyc[i] - start_cyc[i-1], exp_gap(loads[i-1]));
    check("fast_noe_run0", noe_runs[0], B0);
    check("fast_noe_run1", noe_runs[1], B1);
    check("fast_overlap", overlap, 0);

    // enable dropped during SHIFT: no latch, idle after done, restart at (0,0).
    go_idle();
    done_delay = 10;
    en = 1'b1;
    wait_starts(3);
    tick(2);
    en = 1'b0;
    tick(1);
    check("stop_noe_blank", noe, 1);
    tick(40);
    check("stop_no_latch", latch_rows.size(), 2);
    check("stop_no_start", start_cyc.size(), 3);
    check("stop_noe_idle", noe, 1);
    en = 1'b1;
    tick(1);
    check("restart_start", sstart, 1);
    check("restart_srow", srow, 0);
    check("restart_splane", splane, 0);

    // Brief drop mid-transfer: the shift completes, then a fresh (0,0) start.
    tick(2);
    sidx = start_cyc.size() - 1;
    nl = latch_rows.size();
    en = 1'b0;
    tick(2);
    en = 1'b1;
    wait_starts(sidx + 2);
    check("blip_gap", start_cyc[sidx+1] - start_cyc[sidx], 12);
    check("blip_row", start_rows[sidx+1], 0);
    check("blip_plane", start_planes[sidx+1], 0);
    check("blip_no_latch", latch_rows.size(), nl);

    // Asynchronous reset while NOE is low on row 1.
    base = latch_rows.size();
    wait_latches(base + 3);
    k = 0;
    while (noe && k < 50) begin tick(1); k++; end
    check("pre_rst_noe_low", noe, 0);
    check("pre_rst_row", row, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_noe", noe, 1);
    check("async_rst_row", row, 0);
    check("async_rst_latch", latch, 0);
    check("async_rst_srow", srow, 0);
    check("async_rst_splane", splane, 0);
    en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);

`ifdef HUB75_BRIGHT_EN
    // brightness=0: the scan runs but NOE never goes low.
    clear_log();
    bright = 8'd0;
    en = 1'b1;
    wait_latches(4);
    check("dark_noe_runs", noe_runs.size() + cur_noe, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("dark_row%0d", i), latch_rows[i], i / 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
